// File: rtl/instr_fetch_unit_pkg.sv
// Shared architecture defines: fetch buffer depth, machine word width,
// pipeline stage and instruction-type encodings used across the core.
package instr_fetch_unit_pkg;

  localparam int unsigned FETCH_DEPTH = 4;
  localparam int unsigned WORD_W      = 32;

  typedef enum logic [2:0] {
    STG_FETCH     = 3'd0,
    STG_DECODE    = 3'd1,
    STG_ISSUE     = 3'd2,
    STG_EXECUTE   = 3'd3,
    STG_WRITEBACK = 3'd4
  } stage_e;

  typedef enum logic [1:0] {
    ITYPE_ALU    = 2'd0,
    ITYPE_MEM    = 2'd1,
    ITYPE_BRANCH = 2'd2,
    ITYPE_SYSTEM = 2'd3
  } instr_type_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with a registered head.
// The head (head_valid_o/head_data_o) is a flop copy of the oldest entry and
// is loaded in the same edge that writes an entry into an empty buffer.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   push_i, push_data_i   write one entry
//   pop_i                 consume the head
//   flush_i               drop every entry (a push in the same cycle is dropped)
//   full_o, empty_o       occupancy flags
//   count_o               occupancy, 0..DEPTH
//   head_valid_o          head holds an entry
//   head_data_o           head entry
module fetch_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          head_valid_o,
  output logic [DATA_W-1:0]             head_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              pop_ok, push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);

  // Next pointers/occupancy and next head; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    if (flush_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
      head_data_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d      = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      head_valid_d = (count_d != '0);
      if (count_d == '0) begin
        head_data_d = '0;
      end else if ((count_q - CNT_W'(pop_ok)) == '0) begin
        // No older entry survives this cycle: the entry being pushed becomes the head.
        head_data_d = push_data_i;
      end else begin
        head_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Storage array; no reset needed, contents qualified by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign head_valid_o = head_valid_q;
  assign head_data_o  = head_data_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-based instruction prefetcher with redirect support.
// Requests one word per cycle while buffer credits remain, captures the
// response one cycle later into fetch_fifo, and presents the oldest entry
// on registered instr_valid/instr/instr_pc outputs.
// Ports:
//   clk, rst                 clock, async active-low reset
//   mem_req, mem_raddr       memory read request and word address
//   mem_rdata                read data, one cycle after the request
//   redirect, redirect_pc    restart fetch at a new word address
//   instr_valid/instr/instr_pc  buffer head
//   instr_ready              consumer accepts the head this cycle
module instr_fetch_unit #(
  parameter int unsigned DEPTH  = instr_fetch_unit_pkg::FETCH_DEPTH,
  parameter int unsigned WORD_W = instr_fetch_unit_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_raddr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned CRD_W = CNT_W + 1;

  logic [WORD_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0]   req_pc_q, req_pc_d;
  logic                inflight_q, inflight_d;
  logic                pop, push, squash;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full, fifo_empty;
  logic [2*WORD_W-1:0] head_data;
  logic [CRD_W-1:0]    credits_used;

  assign pop    = instr_valid && instr_ready;
  // A response arriving in a redirect cycle belongs to the abandoned path.
  assign squash = redirect && inflight_q;
  assign push   = inflight_q && !squash;

  // Buffered entries plus the outstanding response, less a same-cycle pop.
  assign credits_used = CRD_W'(fifo_count) + CRD_W'(inflight_q) - CRD_W'(pop);
  assign mem_req      = rst && !redirect && (credits_used < CRD_W'(DEPTH));
  assign mem_raddr    = fetch_pc_q;

  // Fetch address and in-flight tracking; a redirect overrides the increment.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = mem_req;
    if (mem_req) begin
      fetch_pc_d = fetch_pc_q + WORD_W'(1);
      req_pc_d   = fetch_pc_q;
    end
    if (redirect) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (2 * WORD_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst),
    .push_i       (push),
    .push_data_i  ({mem_rdata, req_pc_q}),
    .pop_i        (pop),
    .flush_i      (redirect),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .head_valid_o (instr_valid),
    .head_data_o  (head_data)
  );

  assign instr    = head_data[2*WORD_W-1:WORD_W];
  assign instr_pc = head_data[WORD_W-1:0];

  // Credit accounting must never land a response in a full buffer without a pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(push && fifo_full && !pop));

  // The registered head and the occupancy count must agree.
  a_head_consistent : assert property (@(posedge clk) disable iff (!rst)
    instr_valid == !fifo_empty);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit #(.DEPTH(4), .WORD_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word i holds i+100, returned the cycle after the request; junk otherwise.
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= mem_raddr + 32'd100;
    else         mem_rdata <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        rst;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rdy, input logic req,
                              input logic [31:0] addr, input logic v,
                              input logic [31:0] pc, input logic [31:0] ins);
    vec_t x;
    x.rst = r; x.ready = rdy; x.req = req; x.addr = addr; x.v = v; x.pc = pc; x.ins = ins;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard step: compare a pop, drop expectations on redirect, record a new request.
  task automatic sb_sample();
    sb_t e;
    if (!rst) begin
      sb_q.delete();
    end else begin
      if (instr_valid && instr_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_pop: got pc %0h, required no valid head", instr_pc);
        end else begin
          e = sb_q.pop_front();
          chk("sb_pc", 64'(instr_pc), 64'(e.pc));
          chk("sb_instr", 64'(instr), 64'(e.ins));
        end
      end
      if (redirect) sb_q.delete();
      if (mem_req) begin
        e.pc  = mem_raddr;
        e.ins = mem_raddr + 32'd100;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst         = r;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    @(negedge clk);
    sb_sample();
  endtask

  task automatic expect_state(input string tag, input logic in_rst, input logic req,
                              input logic [31:0] addr, input logic v,
                              input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".mem_req"}, 64'(mem_req), 64'(req));
    chk({tag, ".mem_raddr"}, 64'(mem_raddr), 64'(addr));
    chk({tag, ".instr_valid"}, 64'(instr_valid), 64'(v));
    if (v || !in_rst) begin
      chk({tag, ".instr_pc"}, 64'(instr_pc), 64'(pc));
      chk({tag, ".instr"}, 64'(instr), 64'(ins));
    end
  endtask

  initial begin
    rst         = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset, release with ready high, then reset and release under backpressure.
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 2, 1, 0, 100));
    vecs.push_back(mk(1, 1, 1, 3, 1, 1, 101));
    vecs.push_back(mk(1, 1, 1, 4, 1, 2, 102));
    vecs.push_back(mk(1, 1, 1, 5, 1, 3, 103));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 2, 1, 0, 100));
    vecs.push_back(mk(1, 0, 1, 3, 1, 0, 100));
    vecs.push_back(mk(1, 0, 0, 4, 1, 0, 100));
    vecs.push_back(mk(1, 0, 0, 4, 1, 0, 100));
    vecs.push_back(mk(1, 1, 1, 4, 1, 0, 100));
    vecs.push_back(mk(1, 1, 1, 5, 1, 1, 101));
    vecs.push_back(mk(1, 1, 1, 6, 1, 2, 102));
    vecs.push_back(mk(1, 1, 1, 7, 1, 3, 103));
    vecs.push_back(mk(1, 1, 1, 8, 1, 4, 104));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].ready, 1'b0, '0);
      expect_state($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].addr,
                   vecs[i].v, vecs[i].pc, vecs[i].ins);
    end

    // Redirect to 0x40 with 3 buffered entries and one response in flight.
    cyc(0, 0, 0, 0);          expect_state("rd40_rst", 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0);          expect_state("rd40_c1", 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0);          expect_state("rd40_c2", 1, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0);          expect_state("rd40_c3", 1, 1, 2, 1, 0, 100);
    cyc(1, 0, 0, 0);          expect_state("rd40_c4", 1, 1, 3, 1, 0, 100);
    cyc(1, 0, 1, 32'h40);     expect_state("rd40_c5", 1, 0, 4, 1, 0, 100);
    cyc(1, 1, 0, 0);          expect_state("rd40_c6", 1, 1, 32'h40, 0, 0, 0);
    cyc(1, 1, 0, 0);          expect_state("rd40_c7", 1, 1, 32'h41, 0, 0, 0);
    cyc(1, 1, 0, 0);          expect_state("rd40_c8", 1, 1, 32'h42, 1, 32'h40, 32'hA4);
    cyc(1, 1, 0, 0);          expect_state("rd40_c9", 1, 1, 32'h43, 1, 32'h41, 32'hA5);

    // Redirect together with a pop on a full buffer, then a second redirect.
    cyc(0, 0, 0, 0);          expect_state("rdpop_rst", 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0);          expect_state("rdpop_c1", 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0);          expect_state("rdpop_c2", 1, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0);          expect_state("rdpop_c3", 1, 1, 2, 1, 0, 100);
    cyc(1, 0, 0, 0);          expect_state("rdpop_c4", 1, 1, 3, 1, 0, 100);
    cyc(1, 0, 0, 0);          expect_state("rdpop_c5", 1, 0, 4, 1, 0, 100);
    cyc(1, 1, 1, 32'h80);     expect_state("rdpop_c6", 1, 0, 4, 1, 0, 100);
    cyc(1, 1, 1, 32'h90);     expect_state("rdpop_c7", 1, 0, 32'h80, 0, 0, 0);
    cyc(1, 1, 0, 0);          expect_state("rdpop_c8", 1, 1, 32'h90, 0, 0, 0);
    cyc(1, 1, 0, 0);          expect_state("rdpop_c9", 1, 1, 32'h91, 0, 0, 0);
    cyc(1, 1, 0, 0);          expect_state("rdpop_c10", 1, 1, 32'h92, 1, 32'h90, 32'hF4);

    // Redirect to the last word address: fetch wraps to 0.
    cyc(1, 1, 1, 32'hFFFF_FFFF); expect_state("wrap_c1", 1, 0, 32'h93, 1, 32'h91, 32'hF5);
    cyc(1, 1, 0, 0);          expect_state("wrap_c2", 1, 1, 32'hFFFF_FFFF, 0, 0, 0);
    cyc(1, 1, 0, 0);          expect_state("wrap_c3", 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0);          expect_state("wrap_c4", 1, 1, 1, 1, 32'hFFFF_FFFF, 32'd99);
    cyc(1, 1, 0, 0);          expect_state("wrap_c5", 1, 1, 2, 1, 0, 100);
    cyc(1, 1, 0, 0);          expect_state("wrap_c6", 1, 1, 3, 1, 1, 101);

    // Reset pulsed mid-cycle with 2 entries buffered and a response pending.
    cyc(0, 0, 0, 0);          expect_state("mid_rst", 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0);          expect_state("mid_c1", 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0);          expect_state("mid_c2", 1, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0);          expect_state("mid_c3", 1, 1, 2, 1, 0, 100);
    cyc(1, 0, 0, 0);          expect_state("mid_c4", 1, 1, 3, 1, 0, 100);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_async.instr_valid", 64'(instr_valid), 64'(0));
    chk("mid_async.instr", 64'(instr), 64'(0));
    chk("mid_async.instr_pc", 64'(instr_pc), 64'(0));
    chk("mid_async.mem_req", 64'(mem_req), 64'(0));
    chk("mid_async.mem_raddr", 64'(mem_raddr), 64'(0));
    cyc(0, 1, 0, 0);          expect_state("mid_hold", 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0);          expect_state("mid_r1", 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0);          expect_state("mid_r2", 1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0);          expect_state("mid_r3", 1, 1, 2, 1, 0, 100);
    cyc(1, 1, 0, 0);          expect_state("mid_r4", 1, 1, 3, 1, 1, 101);
    cyc(1, 1, 0, 0);          expect_state("mid_r5", 1, 1, 4, 1, 2, 102);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
